// File: rtl/fp_mul_pkg.sv
// fp_mul_pkg: shared definitions for the floating-point multiplier datapath.
//   CLS_* : 2-bit result class encoding carried between multiplier stages.
//   fp_bias(ew) : exponent bias for an ew-bit exponent field.
package fp_mul_pkg;

  localparam logic [1:0] CLS_NORMAL = 2'b00;
  localparam logic [1:0] CLS_ZERO   = 2'b01;
  localparam logic [1:0] CLS_INF    = 2'b10;
  localparam logic [1:0] CLS_NAN    = 2'b11;

  function automatic int fp_bias(input int ew);
    return (1 << (ew - 1)) - 1;
  endfunction

endpackage

// File: rtl/fp_lzc.sv
// fp_lzc: combinational leading-zero counter.
//   x_i   [W-1:0]  value to scan, MSB first
//   cnt_o [CW-1:0] number of leading zeros, W when x_i is all zero
module fp_lzc #(
  parameter int W  = 24,
  parameter int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  x_i,
  output logic [CW-1:0] cnt_o
);

  // Ascending scan: the highest set bit is the last one to write the count.
  always_comb begin
    cnt_o = CW'(W);
    for (int i = 0; i < W; i++) begin
      if (x_i[i]) cnt_o = CW'(W - 1 - i);
    end
  end

endmodule

// File: rtl/fp_mul_unpack.sv
// fp_mul_unpack: two-stage operand unpack for the FP multiplier.
//   clk, reset          rising-edge clock, async active-high reset
//   in_valid/in_ready   operand pair handshake; a, b packed {sign, exp, frac}
//   out_valid/out_ready result handshake
//   out_sign            sign(a) ^ sign(b)
//   out_a/b_mant        normalised mantissas, hidden bit at MSB (0 if not normal)
//   out_exp             signed eff_exp(a) + eff_exp(b) - BIAS (0 if not normal)
//   out_class           CLS_NORMAL / CLS_ZERO / CLS_INF / CLS_NAN
// Stage 1 captures raw fields and per-operand class flags; stage 2 normalises
// subnormals, sums exponents and resolves the final class.
module fp_mul_unpack
  import fp_mul_pkg::*;
#(
  parameter int E_WIDTH = 8,
  parameter int M_WIDTH = 23,
  parameter bit DAZ     = 1'b0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [E_WIDTH+M_WIDTH:0]   a,
  input  logic [E_WIDTH+M_WIDTH:0]   b,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_sign,
  output logic [M_WIDTH:0]           out_a_mant,
  output logic [M_WIDTH:0]           out_b_mant,
  output logic [E_WIDTH+1:0]         out_exp,
  output logic [1:0]                 out_class
);

  localparam int OW  = E_WIDTH + M_WIDTH + 1;
  localparam int XW  = E_WIDTH + 2;
  localparam int MW1 = M_WIDTH + 1;
  localparam int CW  = $clog2(MW1 + 1);
  localparam logic [XW-1:0] BIAS_X = XW'(fp_bias(E_WIDTH));

  typedef struct packed {
    logic               sgn;
    logic [E_WIDTH-1:0] exp;
    logic [M_WIDTH-1:0] frac;
    logic               zero;  // true zero, or subnormal flushed by DAZ
    logic               sub;   // subnormal still to be normalised
    logic               inf;
    logic               nan;
  } s1_op_t;

  // ---- handshake -------------------------------------------------------
  logic [2:1] vld_pipe_q, vld_pipe_d;
  logic       s1_advance, s2_load, s1_load;

  assign s1_advance = vld_pipe_q[2] ? out_ready : 1'b1;
  assign in_ready   = ~vld_pipe_q[1] | s1_advance;
  assign s1_load    = in_valid & in_ready;
  assign s2_load    = s1_advance & vld_pipe_q[1];

  always_comb begin
    vld_pipe_d = vld_pipe_q;
    if (in_ready)   vld_pipe_d[1] = in_valid;
    if (s1_advance) vld_pipe_d[2] = vld_pipe_q[1];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) vld_pipe_q <= '0;
    else       vld_pipe_q <= vld_pipe_d;
  end

  // ---- stage 1: field split and per-operand classification ------------
  logic   [1:0][OW-1:0] op_in;
  s1_op_t [1:0]         s1_q, s1_d;

  // Stage-2 per-operand combinational results.
  logic [1:0][CW-1:0]  lz;
  logic [1:0][MW1-1:0] mant_c;
  logic [1:0][XW-1:0]  eexp_c;

  assign op_in = {b, a};

  for (genvar i = 0; i < 2; i++) begin : gen_op
    logic [E_WIDTH-1:0] exp_in;
    logic [M_WIDTH-1:0] frac_in;
    logic               exp_zero, exp_ones, frac_nz;

    assign exp_in   = op_in[i][OW-2:M_WIDTH];
    assign frac_in  = op_in[i][M_WIDTH-1:0];
    assign exp_zero = (exp_in == '0);
    assign exp_ones = &exp_in;
    assign frac_nz  = |frac_in;

    assign s1_d[i].sgn  = op_in[i][OW-1];
    assign s1_d[i].exp  = exp_in;
    assign s1_d[i].frac = frac_in;
    assign s1_d[i].zero = exp_zero & (~frac_nz | DAZ);
    assign s1_d[i].sub  = exp_zero & frac_nz & ~DAZ;
    assign s1_d[i].inf  = exp_ones & ~frac_nz;
    assign s1_d[i].nan  = exp_ones & frac_nz;

    // Stage 2: a subnormal's leading-zero count both shifts the hidden
    // position into the MSB and lowers the effective exponent below 1.
    fp_lzc #(.W(MW1), .CW(CW)) u_lzc (
      .x_i   ({1'b0, s1_q[i].frac}),
      .cnt_o (lz[i])
    );

    assign mant_c[i] = s1_q[i].sub ? ({1'b0, s1_q[i].frac} << lz[i])
                                   : {1'b1, s1_q[i].frac};
    assign eexp_c[i] = s1_q[i].sub ? (XW'(1) - XW'(lz[i]))
                                   : XW'(s1_q[i].exp);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)        s1_q <= '0;
    else if (s1_load) s1_q <= s1_d;
  end

  // ---- stage 2: final class, exponent sum ------------------------------
  logic                 sign_q, sign_d;
  logic [1:0][MW1-1:0]  mant_q, mant_d;
  logic [XW-1:0]        exp_q, exp_d;
  logic [1:0]           cls_q, cls_d;
  logic                 any_nan, any_inf, any_zero;

  // zero x inf has no meaningful product, so it resolves to NaN.
  assign any_nan  = s1_q[0].nan | s1_q[1].nan |
                    (s1_q[0].zero & s1_q[1].inf) | (s1_q[0].inf & s1_q[1].zero);
  assign any_inf  = s1_q[0].inf | s1_q[1].inf;
  assign any_zero = s1_q[0].zero | s1_q[1].zero;

  always_comb begin
    cls_d = CLS_NORMAL;
    if (any_nan)       cls_d = CLS_NAN;
    else if (any_inf)  cls_d = CLS_INF;
    else if (any_zero) cls_d = CLS_ZERO;
  end

  always_comb begin
    sign_d = s1_q[0].sgn ^ s1_q[1].sgn;
    mant_d = '0;
    exp_d  = '0;
    if (cls_d == CLS_NORMAL) begin
      mant_d = mant_c;
      exp_d  = eexp_c[0] + eexp_c[1] - BIAS_X;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sign_q <= 1'b0;
      mant_q <= '0;
      exp_q  <= '0;
      cls_q  <= CLS_NORMAL;
    end else if (s2_load) begin
      sign_q <= sign_d;
      mant_q <= mant_d;
      exp_q  <= exp_d;
      cls_q  <= cls_d;
    end
  end

  assign out_valid  = vld_pipe_q[2];
  assign out_sign   = sign_q;
  assign out_a_mant = mant_q[0];
  assign out_b_mant = mant_q[1];
  assign out_exp    = exp_q;
  assign out_class  = cls_q;

endmodule

// File: tb/tb_fp_mul_unpack.sv
module tb_fp_mul_unpack;

  typedef struct packed {
    logic        sign;
    logic [23:0] ma;
    logic [23:0] mb;
    logic [9:0]  ex;
    logic [1:0]  cls;
  } res_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] a, b;
  logic        out_sign;
  logic [23:0] out_a_mant, out_b_mant;
  logic [9:0]  out_exp;
  logic [1:0]  out_class;

  logic        in_valid2, in_ready2, out_valid2;
  logic [31:0] a2, b2;
  logic        out_sign2;
  logic [23:0] out_a_mant2, out_b_mant2;
  logic [9:0]  out_exp2;
  logic [1:0]  out_class2;

  int   checks = 0;
  int   errors = 0;
  res_t exp_q[$];
  bit   stream_on = 1'b0;
  bit   stream_done;

  always #5 clk = ~clk;

  fp_mul_unpack #(.E_WIDTH(8), .M_WIDTH(23), .DAZ(1'b0)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .out_sign(out_sign), .out_a_mant(out_a_mant), .out_b_mant(out_b_mant),
    .out_exp(out_exp), .out_class(out_class));

  fp_mul_unpack #(.E_WIDTH(8), .M_WIDTH(23), .DAZ(1'b1)) dut_daz (
    .clk(clk), .reset(reset), .in_valid(in_valid2), .in_ready(in_ready2),
    .a(a2), .b(b2), .out_valid(out_valid2), .out_ready(1'b1),
    .out_sign(out_sign2), .out_a_mant(out_a_mant2), .out_b_mant(out_b_mant2),
    .out_exp(out_exp2), .out_class(out_class2));

  function automatic res_t cur_out();
    return {out_sign, out_a_mant, out_b_mant, out_exp, out_class};
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // Reference model: classes 0 normal, 1 zero, 2 inf, 3 nan.
  function automatic res_t model(input logic [31:0] x, input logic [31:0] y, input bit daz);
    logic [31:0] op[2];
    int          e, cl[2], ee[2], p;
    logic [22:0] f;
    logic [23:0] m[2];
    res_t        r;
    op[0] = x; op[1] = y;
    for (int k = 0; k < 2; k++) begin
      e = int'(op[k][30:23]);
      f = op[k][22:0];
      m[k] = '0; ee[k] = 0;
      if (e == 0 && f == 0)  cl[k] = 1;
      else if (e == 255)     cl[k] = (f == 0) ? 2 : 3;
      else if (e == 0 && daz) cl[k] = 1;
      else if (e == 0) begin
        p = 0;
        for (int j = 0; j < 23; j++) if (f[j]) p = j;
        cl[k] = 0;
        m[k]  = {1'b0, f} << (23 - p);
        ee[k] = 1 - (23 - p);
      end else begin
        cl[k] = 0;
        m[k]  = {1'b1, f};
        ee[k] = e;
      end
    end
    r.sign = op[0][31] ^ op[1][31];
    r.ma = '0; r.mb = '0; r.ex = '0;
    if (cl[0] == 3 || cl[1] == 3 || (cl[0] == 1 && cl[1] == 2) || (cl[0] == 2 && cl[1] == 1))
      r.cls = 2'b11;
    else if (cl[0] == 2 || cl[1] == 2) r.cls = 2'b10;
    else if (cl[0] == 1 || cl[1] == 1) r.cls = 2'b01;
    else begin
      r.cls = 2'b00;
      r.ma  = m[0];
      r.mb  = m[1];
      r.ex  = 10'(ee[0] + ee[1] - 127);
    end
    return r;
  endfunction

  // Called right after a rising edge; returns right after the accepting edge.
  task automatic send(input logic [31:0] av, input logic [31:0] bv, input res_t e);
    int n;
    bit ok;
    in_valid = 1'b1; a = av; b = bv;
    n = 0; ok = 1'b0;
    while (!ok && n < 200) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      n++;
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL accept_timeout: got in_ready=0 want 1 within 200 cycles");
    end else begin
      @(posedge clk);
      exp_q.push_back(e);
    end
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  // Monitor: pops on every output transfer and checks hold stability.
  initial begin
    bit   hold;
    res_t held, got, want;
    hold = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (reset) hold = 1'b0;
      else begin
        got = cur_out();
        if (hold) begin
          chk("hold_valid", 64'(out_valid), 64'd1);
          chk("hold_stable", 64'(got), 64'(held));
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_output: got %h want none", got);
          end else begin
            want = exp_q.pop_front();
            chk("result", 64'(got), 64'(want));
          end
        end
        hold = out_valid && !out_ready;
        held = got;
      end
    end
  end

  // Steady-state throughput: with in_valid held high both stages stay full,
  // so out_valid stays high and in_ready follows out_ready.
  initial begin
    forever begin
      @(negedge clk);
      if (stream_on) begin
        chk("stream_out_valid", 64'(out_valid), 64'd1);
        chk("stream_in_ready", 64'(in_ready), 64'(out_ready));
      end
    end
  end

  logic [31:0] hv_a[5], hv_b[5];
  res_t        hv_e[5];
  logic [31:0] pool[10];

  initial begin
    hv_a[0] = 32'h3F800000; hv_b[0] = 32'h40000000; hv_e[0] = {1'b0, 24'h800000, 24'h800000, 10'd128, 2'b00};
    hv_a[1] = 32'h00000001; hv_b[1] = 32'h3F800000; hv_e[1] = {1'b0, 24'h800000, 24'h800000, 10'h3EA, 2'b00};
    hv_a[2] = 32'h00000000; hv_b[2] = 32'h7F800000; hv_e[2] = {1'b0, 24'h0, 24'h0, 10'd0, 2'b11};
    hv_a[3] = 32'h7F800000; hv_b[3] = 32'hC0000000; hv_e[3] = {1'b1, 24'h0, 24'h0, 10'd0, 2'b10};
    hv_a[4] = 32'h7FC00000; hv_b[4] = 32'h3F800000; hv_e[4] = {1'b0, 24'h0, 24'h0, 10'd0, 2'b11};
    pool = '{32'h3F800000, 32'hC0400000, 32'h00400000, 32'h80000003,
             32'h007FFFFF, 32'h00000000, 32'h7F800000, 32'h7FC00001,
             32'h7F7FFFFF, 32'h00800000};

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
    in_valid2 = 1'b0; a2 = '0; b2 = '0;
    #1;
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_outputs", 64'(cur_out()), 64'd0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("in_ready_after_reset", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    // Directed vectors, back to back.
    for (int i = 0; i < 5; i++) send(hv_a[i], hv_b[i], hv_e[i]);
    drain();

    // Denormals-are-zero instance.
    begin
      bit   seen;
      res_t got2;
      in_valid2 = 1'b1; a2 = 32'h00000001; b2 = 32'h3F800000;
      @(posedge clk); #1 in_valid2 = 1'b0;
      seen = 1'b0;
      for (int n = 0; n < 10 && !seen; n++) begin
        @(negedge clk);
        if (out_valid2) seen = 1'b1;
      end
      chk("daz_seen", 64'(seen), 64'd1);
      got2 = {out_sign2, out_a_mant2, out_b_mant2, out_exp2, out_class2};
      chk("daz_result", 64'(got2), 64'({1'b0, 24'h0, 24'h0, 10'd0, 2'b01}));
    end
    @(posedge clk); #1;

    // Stall: two accepts fill the pipe, third waits while outputs hold.
    out_ready = 1'b0;
    send(hv_a[0], hv_b[0], hv_e[0]);
    send(hv_a[1], hv_b[1], hv_e[1]);
    in_valid = 1'b1; a = hv_a[3]; b = hv_b[3];
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("stall_in_ready", 64'(in_ready), 64'd0);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    send(hv_a[3], hv_b[3], hv_e[3]);
    drain();
    @(posedge clk); #1;

    // Continuous stream with random backpressure.
    stream_done = 1'b0;
    fork
      begin
        logic [31:0] x, y;
        for (int i = 0; i < 40; i++) begin
          x = pool[$urandom_range(0, 9)];
          y = pool[$urandom_range(0, 9)];
          if (i == 3) stream_on = 1'b1;
          send(x, y, model(x, y, 1'b0));
          in_valid = 1'b1;
        end
        stream_on = 1'b0;
        in_valid = 1'b0;
        stream_done = 1'b1;
      end
      begin
        while (!stream_done) begin
          @(posedge clk);
          #1 out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    drain();
    @(posedge clk); #1;

    // Reset with two pairs in flight.
    out_ready = 1'b0;
    send(hv_a[0], hv_b[0], hv_e[0]);
    send(hv_a[3], hv_b[3], hv_e[3]);
    #3 reset = 1'b1;
    #1;
    chk("midreset_out_valid", 64'(out_valid), 64'd0);
    chk("midreset_outputs", 64'(cur_out()), 64'd0);
    exp_q.delete();
    @(posedge clk); #1 reset = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("in_ready_after_midreset", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    send(hv_a[1], hv_b[1], hv_e[1]);
    @(negedge clk);
    chk("latency_cycle1", 64'(out_valid), 64'd0);
    @(negedge clk);
    chk("latency_cycle2", 64'(out_valid), 64'd1);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
